// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use interlock, taken-branch
// flush, multi-cycle MULT/DIV occupancy of EX, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             id_branch_taken,
  input  logic             ex_md_start,
  input  logic             cnt_clear,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             bubble_idex,
  output logic             bubble_exmem,
  output logic             is_branch,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MD_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  // The first stall cycle is spent in IDLE, so BUSY only needs MD_LATENCY-1 cycles.
  localparam logic [MD_W-1:0] MD_RELOAD = MD_W'(MD_LATENCY - 2);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic md_stall;
  logic rs_hit;
  logic rt_hit;
  logic lu;

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    md_stall     = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ex_md_start) begin
          md_stall = 1'b1;
          state_d  = BUSY;
          md_cnt_d = MD_RELOAD;
        end
      end
      BUSY: begin
        md_stall = 1'b1;
        md_busy  = 1'b1;
        if (md_cnt_q == '0) begin
          md_done = 1'b1;
          state_d = IDLE;
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Load-use only matters when EX actually holds a load to a non-zero register.
  always_comb begin
    rs_hit = id_uses_rs && (id_rs == ex_rd);
    rt_hit = id_uses_rt && (id_rt == ex_rd);
    lu     = !md_stall && ex_mem_read && (ex_rd != 5'd0) && (rs_hit || rt_hit);
  end

  always_comb begin
    stall_pc     = md_stall || lu;
    stall_ifid   = md_stall || lu;
    stall_idex   = md_stall;
    bubble_exmem = md_stall;
    bubble_idex  = lu;
    is_branch    = id_branch_taken && !md_stall && !lu;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (cnt_clear) begin
      stall_cycles_d = '0;
    end else if (stall_pc && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      md_cnt_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      md_cnt_q       <= md_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level reference model checked
// on every falling edge, plus literal expectations at key points.
module tb_pipe_hazard_ctrl;

  localparam int MD_LATENCY = 4;
  localparam int CNT_W      = 3;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_rd;
  logic             id_uses_rs, id_uses_rt, ex_mem_read;
  logic             id_branch_taken, ex_md_start, cnt_clear;
  logic             stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem;
  logic             is_branch, md_busy, md_done;
  logic [CNT_W-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_branch_taken(id_branch_taken),
    .ex_md_start(ex_md_start), .cnt_clear(cnt_clear),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .bubble_idex(bubble_idex), .bubble_exmem(bubble_exmem), .is_branch(is_branch),
    .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining MD cycles after the current one, and the stall count.
  int  busy_left = 0;
  int  cnt_m     = 0;
  bit  model_ok  = 1'b0;

  always @(negedge clk) begin
    bit md, lu, stall;
    md = (busy_left > 0) || (ex_md_start === 1'b1);
    lu = !md && ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    stall = md || lu;
    if (model_ok) begin
      check("m_stall_pc",     int'(stall_pc),     int'(stall));
      check("m_stall_ifid",   int'(stall_ifid),   int'(stall));
      check("m_stall_idex",   int'(stall_idex),   int'(md));
      check("m_bubble_idex",  int'(bubble_idex),  int'(lu));
      check("m_bubble_exmem", int'(bubble_exmem), int'(md));
      check("m_is_branch",    int'(is_branch),    int'(id_branch_taken && !md && !lu));
      check("m_md_busy",      int'(md_busy),      int'(busy_left > 0));
      check("m_md_done",      int'(md_done),      int'(busy_left == 1));
      check("m_stall_cycles", int'(stall_cycles), cnt_m);
    end
    if (rst) begin
      busy_left = 0;
      cnt_m     = 0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (cnt_clear) cnt_m = 0;
      else if (stall && cnt_m < CNT_MAX) cnt_m++;
      if (busy_left > 0) busy_left--;
      else if (ex_md_start) busy_left = MD_LATENCY - 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; ex_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
    id_branch_taken = 0; ex_md_start = 0; cnt_clear = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic uses_rs);
    ex_mem_read = 1; ex_rd = rd; id_rs = 5'd8; id_uses_rs = uses_rs;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    @(negedge clk);
    $display("reset released");
    check("rst_stall_pc", int'(stall_pc), 0);
    check("rst_stall_cycles", int'(stall_cycles), 0);
    check("rst_md_busy", int'(md_busy), 0);
    cyc();

    // MD sequence T0..T3
    ex_md_start = 1;
    for (int t = 0; t < MD_LATENCY; t++) begin
      @(negedge clk);
      $display("md cycle T%0d", t);
      check("md_stall_pc", int'(stall_pc), 1);
      check("md_stall_idex", int'(stall_idex), 1);
      check("md_bubble_exmem", int'(bubble_exmem), 1);
      check("md_done_pulse", int'(md_done), (t == MD_LATENCY - 1) ? 1 : 0);
      check("md_busy_t", int'(md_busy), (t == 0) ? 0 : 1);
      cyc();
    end
    ex_md_start = 0;
    @(negedge clk);
    $display("md cycle T4");
    check("md_t4_stall_pc", int'(stall_pc), 0);
    check("md_t4_busy", int'(md_busy), 0);
    check("md_t4_count", int'(stall_cycles), 4);
    cnt_clear = 1;
    cyc();
    cnt_clear = 0;

    // Load-use
    set_lu(5'd8, 1'b1);
    @(negedge clk);
    $display("load-use rs hit");
    check("lu_stall_pc", int'(stall_pc), 1);
    check("lu_stall_ifid", int'(stall_ifid), 1);
    check("lu_bubble_idex", int'(bubble_idex), 1);
    check("lu_stall_idex", int'(stall_idex), 0);
    cyc();
    set_lu(5'd0, 1'b1);
    id_rs = 5'd0;
    @(negedge clk);
    $display("load-use rd zero");
    check("lu_rd0_stall", int'(stall_pc), 0);
    cyc();
    set_lu(5'd8, 1'b0);
    @(negedge clk);
    $display("load-use rs unused");
    check("lu_nouse_stall", int'(stall_pc), 0);
    cyc();
    id_uses_rt = 1; id_rt = 5'd8;
    @(negedge clk);
    $display("load-use rt hit");
    check("lu_rt_stall", int'(stall_pc), 1);
    cyc();
    idle_inputs();

    // Branch vs load-use
    set_lu(5'd8, 1'b1);
    id_branch_taken = 1;
    @(negedge clk);
    $display("branch with load-use");
    check("br_lu_is_branch", int'(is_branch), 0);
    check("br_lu_bubble", int'(bubble_idex), 1);
    cyc();
    ex_mem_read = 0;
    @(negedge clk);
    $display("branch released");
    check("br_is_branch", int'(is_branch), 1);
    check("br_stall_pc", int'(stall_pc), 0);
    check("br_bubble", int'(bubble_idex), 0);
    cyc();
    idle_inputs();

    // Branch during MD
    id_branch_taken = 1; ex_md_start = 1;
    for (int t = 0; t < MD_LATENCY; t++) begin
      @(negedge clk);
      $display("branch during md T%0d", t);
      check("br_md_is_branch", int'(is_branch), 0);
      cyc();
    end
    idle_inputs();
    cnt_clear = 1;
    cyc();
    cnt_clear = 0;

    // Counter saturation with a held load-use stall
    set_lu(5'd8, 1'b1);
    for (int t = 0; t < 10; t++) cyc();
    @(negedge clk);
    $display("counter after 10 stall cycles");
    check("cnt_saturated", int'(stall_cycles), CNT_MAX);
    cnt_clear = 1;
    cyc();
    cnt_clear = 0;
    @(negedge clk);
    $display("counter after clear");
    check("cnt_cleared", int'(stall_cycles), 0);
    cyc();
    idle_inputs();
    cyc();

    // Reset mid-BUSY with start held
    ex_md_start = 1;
    cyc(); cyc();
    rst = 1;
    @(negedge clk);
    $display("reset mid-busy");
    check("rstb_done_before", int'(md_done), 0);
    cyc();
    rst = 0;
    ex_md_start = 0;
    @(negedge clk);
    $display("after reset");
    check("rstb_busy", int'(md_busy), 0);
    check("rstb_done", int'(md_done), 0);
    check("rstb_count", int'(stall_cycles), 0);
    check("rstb_stall_pc", int'(stall_pc), 0);
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
